spi_rx: RTL and testbench



---
 rtl/spi_rx.sv | 167 ++++++++++++++++
 tb/tb_spi_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx.sv
// 3-wire SPI receiver: synchronizes SCLK/SDATA/CS, deserializes MSB-first words, buffers them in a show-ahead FIFO.
// Optional macro SPI_RX_FRAME_CHECK_EN enables the sticky frame_err flag for wrong-length frames.
module spi_rx #(
    parameter int WORD_BITS  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 SPI_SCLK,
    input  logic                 SPI_SDATA,
    input  logic                 SPI_CS,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_full,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int CW = $clog2(WORD_BITS + 2);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(WORD_BITS);
    localparam logic [CW-1:0] SAT_CNT  = CW'(WORD_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

    logic r_sclk_meta, r_sclk_sync, r_sclk_dly;
    logic r_sdata_meta, r_sdata_sync, r_sdata_dly;
    logic r_cs_meta, r_cs_sync, r_cs_dly;
    logic r_sclk_rise, r_cs_fall, r_cs_rise;
    logic [1:0] r_warm;
    logic r_armed;

    state_t               r_state;
    logic [WORD_BITS-1:0] r_shift;
    logic [CW-1:0]        r_count;

    logic [WORD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wr_ptr, r_rd_ptr;
    logic                 r_overflow;

    logic w_push, w_pop, w_write;

    // NOTE: every register below uses non-blocking (<=) so all flops sample pre-edge values, like real hardware.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_sclk_meta  <= 1'b0;
            r_sclk_sync  <= 1'b0;
            r_sclk_dly   <= 1'b0;
            r_sdata_meta <= 1'b0;
            r_sdata_sync <= 1'b0;
            r_sdata_dly  <= 1'b0;
            r_cs_meta    <= 1'b1;
            r_cs_sync    <= 1'b1;
            r_cs_dly     <= 1'b1;
            r_sclk_rise  <= 1'b0;
            r_cs_fall    <= 1'b0;
            r_cs_rise    <= 1'b0;
            r_warm       <= 2'b00;
            r_armed      <= 1'b0;
        end else begin
            r_sclk_meta  <= SPI_SCLK;
            r_sclk_sync  <= r_sclk_meta;
            r_sclk_dly   <= r_sclk_sync;
            r_sdata_meta <= SPI_SDATA;
            r_sdata_sync <= r_sdata_meta;
            r_sdata_dly  <= r_sdata_sync;
            r_cs_meta    <= SPI_CS;
            r_cs_sync    <= r_cs_meta;
            r_cs_dly     <= r_cs_sync;
            r_sclk_rise  <= r_sclk_sync & ~r_sclk_dly;
            r_cs_fall    <= ~r_cs_sync & r_cs_dly;
            r_cs_rise    <= r_cs_sync & ~r_cs_dly;
            // Arm only on a real CS-high sample, not the synchronizer's reset value.
            r_warm       <= {r_warm[0], 1'b1};
            r_armed      <= r_armed | (r_warm[1] & r_cs_sync);
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_armed && r_cs_fall) begin
                        r_state <= SHIFT;
                        r_count <= '0;
                    end
                end
                SHIFT: begin
                    if (r_cs_rise) begin
                        r_state <= PUSH;
                    end else if (r_sclk_rise) begin
                        if (r_count < FULL_CNT) begin
                            r_shift <= {r_shift[WORD_BITS-2:0], r_sdata_dly};
                        end
                        if (r_count != SAT_CNT) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                PUSH:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_push  = (r_state == PUSH) && (r_count == FULL_CNT);
    assign w_pop   = rd_en && !rx_empty;
    assign w_write = w_push && (!rx_full || w_pop);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            // NOTE: the storage is reset on purpose so rx_data reads 0 after reset; cheap at this depth.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && rx_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rx_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign rx_empty = (r_wr_ptr == r_rd_ptr);
    assign rx_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign overflow = r_overflow;

`ifdef SPI_RX_FRAME_CHECK_EN
    logic r_frame_err;
    logic w_frame_bad;

    assign w_frame_bad = (r_state == PUSH) && (r_count != FULL_CNT);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_frame_err <= 1'b0;
        end else if (w_frame_bad) begin
            r_frame_err <= 1'b1;
        end else if (err_clr) begin
            r_frame_err <= 1'b0;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: directed SPI frames, a queue-based reference model
// with fixed 5-edge CS-rise-to-data latency, and literal checks pinning key points.
module tb_spi_rx;

    localparam int WB    = 24;
    localparam int DEPTH = 4;
`ifdef SPI_RX_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic clk       = 1'b0;
    logic RSTn      = 1'b1;
    logic SPI_SCLK  = 1'b0;
    logic SPI_SDATA = 1'b0;
    logic SPI_CS    = 1'b1;
    logic rd_en     = 1'b0;
    logic err_clr   = 1'b0;
    logic [WB-1:0] rx_data;
    logic rx_empty, rx_full, overflow, frame_err;

    always #10 clk = ~clk;

    spi_rx #(.WORD_BITS(WB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .RSTn     (RSTn),
        .SPI_SCLK (SPI_SCLK),
        .SPI_SDATA(SPI_SDATA),
        .SPI_CS   (SPI_CS),
        .rd_en    (rd_en),
        .err_clr  (err_clr),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_full  (rx_full),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Last completed frame as driven on the pins; fr_seq bumps on each CS rise.
    int          fr_seq  = 0;
    int          fr_bits = 0;
    logic [31:0] fr_word = '0;

    // Reference model: a word appears at the 5th clk edge after the CS pin rises.
    logic [WB-1:0] q[$];
    bit m_ovf, m_ferr;
    int pend     = 0;
    int seen_seq = 0;

    always @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            q.delete();
            m_ovf    <= 1'b0;
            m_ferr   <= 1'b0;
            pend     <= 0;
            seen_seq <= fr_seq;
        end else begin
            if (err_clr) begin
                m_ovf  <= 1'b0;
                m_ferr <= 1'b0;
            end
            if (rd_en && q.size() > 0) void'(q.pop_front());
            if (fr_seq != seen_seq) begin
                seen_seq <= fr_seq;
                pend     <= 4;
            end else if (pend == 1) begin
                pend <= 0;
                if (fr_bits == WB) begin
                    if (q.size() < DEPTH) q.push_back(fr_word[WB-1:0]);
                    else m_ovf <= 1'b1;
                end else if (FC) begin
                    m_ferr <= 1'b1;
                end
            end else if (pend > 1) begin
                pend <= pend - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_empty", rx_empty, q.size() == 0);
        check("cmp_full", rx_full, q.size() == DEPTH);
        check("cmp_overflow", overflow, m_ovf);
        check("cmp_frame_err", frame_err, m_ferr);
        if (q.size() > 0) check("cmp_data", rx_data, q[0]);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // SCLK at clk/4; optional reset pulse after rst_at bits, which makes the frame unrecorded.
    task automatic send_frame(input logic [31:0] word, input int nbits, input int rst_at);
        SPI_CS = 1'b0;
        wait_cyc(2);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (rst_at > 0 && (nbits - 1 - i) == rst_at) begin
                RSTn = 1'b0;
                wait_cyc(1);
                check("rst_mid_empty", rx_empty, 1);
                check("rst_mid_data", rx_data, 0);
                check("rst_mid_full", rx_full, 0);
                wait_cyc(1);
                RSTn = 1'b1;
                wait_cyc(2);
            end
            SPI_SDATA = word[i];
            wait_cyc(2);
            SPI_SCLK = 1'b1;
            wait_cyc(2);
            SPI_SCLK = 1'b0;
        end
        wait_cyc(2);
        SPI_CS = 1'b1;
        if (rst_at == 0) begin
            fr_word = word;
            fr_bits = nbits;
            fr_seq++;
        end
    endtask

    task automatic pop_expect(input logic [31:0] exp, input string name);
        check(name, rx_data, exp);
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #2 RSTn = 1'b0;
        wait_cyc(2);
        check("rst_data", rx_data, 0);
        check("rst_empty", rx_empty, 1);
        check("rst_full", rx_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        RSTn = 1'b1;
        wait_cyc(3);

        send_frame(32'hA5C3F0, 24, 0);
        wait_cyc(4);
        check("lat_edge4_empty", rx_empty, 1);
        wait_cyc(1);
        check("lat_edge5_empty", rx_empty, 0);
        pop_expect(32'hA5C3F0, "single_data");
        check("single_drained", rx_empty, 1);
        wait_cyc(4);

        for (int k = 1; k <= 5; k++) begin
            send_frame(k, 24, 0);
            wait_cyc(6);
        end
        check("burst_full", rx_full, 1);
        check("burst_overflow", overflow, 1);
        for (int k = 1; k <= 4; k++) pop_expect(k, "burst_pop");
        check("burst_drained", rx_empty, 1);
        clear_errs();
        check("burst_ovf_cleared", overflow, 0);

        send_frame(32'h7ABCDE, 23, 0);
        wait_cyc(6);
        check("short_discard", rx_empty, 1);
        check("short_frame_err", frame_err, FC);
        send_frame(32'h123456, 24, 0);
        wait_cyc(6);
        pop_expect(32'h123456, "short_next_data");
        check("short_next_drained", rx_empty, 1);
        clear_errs();
        check("short_ferr_cleared", frame_err, 0);

        send_frame(32'h1555555, 25, 0);
        wait_cyc(6);
        check("long_discard", rx_empty, 1);
        check("long_frame_err", frame_err, FC);
        clear_errs();

        send_frame(32'h0, 0, 0);
        wait_cyc(6);
        check("zero_discard", rx_empty, 1);
        check("zero_frame_err", frame_err, FC);
        clear_errs();

        for (int k = 1; k <= 4; k++) begin
            send_frame(k * 32'h111111, 24, 0);
            wait_cyc(6);
        end
        check("fp_full_before", rx_full, 1);
        send_frame(32'hFFFFFF, 24, 0);
        wait_cyc(4);
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
        check("fp_overflow", overflow, 0);
        check("fp_full_after", rx_full, 1);
        pop_expect(32'h222222, "fp_pop1");
        pop_expect(32'h333333, "fp_pop2");
        pop_expect(32'h444444, "fp_pop3");
        pop_expect(32'hFFFFFF, "fp_pop_last");
        check("fp_drained", rx_empty, 1);

        send_frame(32'h0F0F0F, 24, 0);
        wait_cyc(6);
        check("pre_rst_word", rx_empty, 0);
        send_frame(32'h5A5A5A, 24, 10);
        wait_cyc(6);
        check("rm_discard", rx_empty, 1);
        check("rm_frame_err", frame_err, 0);
        send_frame(32'hABCDEF, 24, 0);
        wait_cyc(6);
        pop_expect(32'hABCDEF, "rm_next_data");
        check("rm_next_drained", rx_empty, 1);

        wait_cyc(4);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
